// File: rtl/blink_dec_iter.sv
`default_nettype none
// ============================================================================
// blink_dec_iter : iterative 64-bit block decryptor, one inverse round per clk
// Optional final key whitening when BLINK_DEC_WHITEN_EN is defined.  Rev 1.0
// ============================================================================
module blink_dec_iter #(
    parameter int NR = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] ct_i,
    output logic [4:0]  rk_idx_o,
    input  logic [63:0] rk_i,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] pt_o
);

    localparam logic [4:0] LAST_IDX = 5'(NR - 1);

`ifdef BLINK_DEC_WHITEN_EN
    localparam logic [4:0] WHITEN_IDX = 5'(NR);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2, WHITEN = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
`endif

    state_t      state, state_nx;
    logic [63:0] blk;
    logic [4:0]  cnt;
    logic        load, step;
`ifdef BLINK_DEC_WHITEN_EN
    logic        whiten;
`endif

    function automatic logic [3:0] inv_sbox(input logic [3:0] n);
        case (n)
            4'h0: return 4'h5;  4'h1: return 4'hE;  4'h2: return 4'hF;  4'h3: return 4'h8;
            4'h4: return 4'hC;  4'h5: return 4'h1;  4'h6: return 4'h2;  4'h7: return 4'hD;
            4'h8: return 4'hB;  4'h9: return 4'h4;  4'hA: return 4'h6;  4'hB: return 4'h3;
            4'hC: return 4'h0;  4'hD: return 4'h7;  4'hE: return 4'h9;  default: return 4'hA;
        endcase
    endfunction

    // Forward shuffle takes output cell i from input cell shuffle_src(i).
    function automatic int shuffle_src(input int i);
        case (i)
            4:  return 7;   5:  return 4;   6:  return 5;   7:  return 6;
            8:  return 10;  9:  return 11;  10: return 8;   11: return 9;
            12: return 13;  13: return 14;  14: return 15;  15: return 12;
            default: return i;
        endcase
    endfunction

    function automatic logic [63:0] inv_shuffle(input logic [63:0] y);
        logic [63:0] z;
        z = '0;
        for (int i = 0; i < 16; i++) begin
            z[4*shuffle_src(i) +: 4] = y[4*i +: 4];
        end
        return z;
    endfunction

    // Each cell becomes the XOR of the other three in its column; an involution.
    function automatic logic [63:0] mix_columns(input logic [63:0] x);
        logic [63:0] y;
        logic [3:0]  s;
        y = '0;
        for (int col = 0; col < 4; col++) begin
            s = x[4*col +: 4] ^ x[4*(col+4) +: 4] ^ x[4*(col+8) +: 4] ^ x[4*(col+12) +: 4];
            for (int row = 0; row < 4; row++) begin
                y[4*(col+4*row) +: 4] = s ^ x[4*(col+4*row) +: 4];
            end
        end
        return y;
    endfunction

    function automatic logic [63:0] inv_round(input logic [63:0] x, input logic [63:0] k);
        logic [63:0] m;
        logic [63:0] r;
        m = mix_columns(inv_shuffle(x) ^ k);
        for (int i = 0; i < 16; i++) begin
            r[4*i +: 4] = inv_sbox(m[4*i +: 4]);
        end
        return r;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        rk_idx_o  = LAST_IDX;
        load      = 1'b0;
        step      = 1'b0;
`ifdef BLINK_DEC_WHITEN_EN
        whiten    = 1'b0;
`endif
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load     = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                rk_idx_o = cnt;
                step     = 1'b1;
                if (cnt == 5'd0) begin
`ifdef BLINK_DEC_WHITEN_EN
                    state_nx = WHITEN;
`else
                    state_nx = DONE;
`endif
                end
            end
`ifdef BLINK_DEC_WHITEN_EN
            WHITEN: begin
                rk_idx_o = WHITEN_IDX;
                whiten   = 1'b1;
                state_nx = DONE;
            end
`endif
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Counter holds at 0 on the last round; it is reloaded on the next accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk <= '0;
            cnt <= LAST_IDX;
        end else if (load) begin
            blk <= ct_i;
            cnt <= LAST_IDX;
        end else if (step) begin
            blk <= inv_round(blk, rk_i);
            if (cnt != 5'd0) cnt <= cnt - 5'd1;
        end
`ifdef BLINK_DEC_WHITEN_EN
        else if (whiten) begin
            blk <= blk ^ rk_i;
        end
`endif
    end

    assign pt_o = out_valid ? blk : 64'h0;

endmodule
`default_nettype wire

// File: tb/tb_blink_dec_iter.sv
`default_nettype none
// tb_blink_dec_iter : random plaintexts encrypted by a forward-cipher model,
// decrypted by the DUT and checked through a scoreboard queue.
module tb_blink_dec_iter;
    localparam int NR = 16;
    localparam logic [63:0] WKEY = 64'hA5A5A5A5A5A5A5A5;
`ifdef BLINK_DEC_WHITEN_EN
    localparam int WH = 1;
`else
    localparam int WH = 0;
`endif
    localparam int LAT = NR + 1 + WH;
    localparam logic [3:0] SBOX [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                         4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
    localparam int PERM [16] = '{0, 1, 2, 3, 7, 4, 5, 6, 10, 11, 8, 9, 13, 14, 15, 12};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] ct_i = 64'h0;
    logic [4:0]  rk_idx_o;
    logic [63:0] rk_i;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] pt_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [63:0] pt;
        int          acc;
    } item_t;
    item_t       q[$];
    logic [63:0] cur_exp = 64'h0;
    bit          b2b_arm = 1'b0;
    int          last_hs = -100;
    bit          prev_valid = 1'b0;

    blink_dec_iter #(.NR(NR)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ct_i      (ct_i),
        .rk_idx_o  (rk_idx_o),
        .rk_i      (rk_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pt_o      (pt_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] key_of(input int idx);
        logic [3:0] n;
        if (idx == NR) return WKEY;
        n = idx[3:0];
        return {16{n}};
    endfunction

    always_comb rk_i = key_of(int'(rk_idx_o));

    // Forward round: ShuffleCells(MixColumns(SubCells(x)) ^ k).
    function automatic logic [63:0] fwd_round(input logic [63:0] x, input logic [63:0] k);
        logic [3:0]  c [16];
        logic [63:0] m;
        logic [63:0] y;
        logic [3:0]  s;
        m = '0;
        y = '0;
        for (int i = 0; i < 16; i++) c[i] = SBOX[x[4*i +: 4]];
        for (int col = 0; col < 4; col++) begin
            s = c[col] ^ c[col+4] ^ c[col+8] ^ c[col+12];
            for (int row = 0; row < 4; row++) m[4*(col+4*row) +: 4] = s ^ c[col+4*row];
        end
        m = m ^ k;
        for (int i = 0; i < 16; i++) y[4*i +: 4] = m[4*PERM[i] +: 4];
        return y;
    endfunction

    function automatic logic [63:0] encrypt(input logic [63:0] p);
        logic [63:0] x;
        x = p;
        for (int r = 0; r < NR; r++) x = fwd_round(x, key_of(r));
        return x;
    endfunction

    function automatic logic [63:0] expect_pt(input logic [63:0] p);
        return (WH != 0) ? (p ^ WKEY) : p;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Acceptance / handshake bookkeeping, sampled on the active edge.
    always @(posedge clk) begin
        if (rst) begin
            q.delete();
        end else begin
            if (out_valid && out_ready) begin
                last_hs = cyc;
                if (q.size() != 0) void'(q.pop_front());
            end
            if (in_valid && in_ready) begin
                if (b2b_arm) begin
                    chk("b2b_accept_cycle", 64'(cyc), 64'(last_hs + 1));
                    b2b_arm = 1'b0;
                end
                q.push_back('{pt: cur_exp, acc: cyc});
            end
        end
    end

    // Output monitor on the falling edge.
    always @(negedge clk) begin
        int k;
        if (rst) begin
            q.delete();
            prev_valid = 1'b0;
        end else begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_out_valid", 64'(out_valid), 64'h0);
                end else begin
                    if (!prev_valid) chk("latency", 64'(cyc - q[0].acc), 64'(LAT));
                    chk("pt_o", pt_o, q[0].pt);
                    chk("in_ready_done", 64'(in_ready), 64'h0);
                end
            end else begin
                chk("pt_zero", pt_o, 64'h0);
                if (q.size() == 0) begin
                    chk("idle_in_ready", 64'(in_ready), 64'h1);
                    chk("idle_rk_idx", 64'(rk_idx_o), 64'(NR - 1));
                end else begin
                    k = cyc - q[0].acc;
                    chk("in_ready_busy", 64'(in_ready), 64'h0);
                    if (k >= 1 && k <= NR)
                        chk("rk_idx_run", 64'(rk_idx_o), 64'(NR - k));
                    else if (WH != 0 && k == NR + 1)
                        chk("rk_idx_whiten", 64'(rk_idx_o), 64'(NR));
                    else
                        chk("out_valid_missing", 64'(out_valid), 64'h1);
                end
            end
            prev_valid = out_valid;
        end
    end

    task automatic wait_accept();
        int t;
        t = 0;
        do begin
            @(posedge clk);
            t++;
        end while (!in_ready && t < LAT + 10);
        if (t >= LAT + 10) chk("accept_timeout", 64'h1, 64'h0);
    endtask

    task automatic wait_out_valid();
        int t;
        t = 0;
        while (!out_valid && t < LAT + 5) begin
            @(negedge clk);
            t++;
        end
        if (!out_valid) chk("out_valid_timeout", 64'h0, 64'h1);
    endtask

    task automatic send(input logic [63:0] p, input int bp);
        @(negedge clk);
        ct_i     = encrypt(p);
        cur_exp  = expect_pt(p);
        in_valid = 1'b1;
        wait_accept();
        @(negedge clk);
        in_valid = 1'b0;
        ct_i     = 64'h0;
        wait_out_valid();
        if (bp > 0) begin
            in_valid = 1'b1;
            ct_i     = 64'hFFFF_FFFF_FFFF_FFFF;
            repeat (bp) @(negedge clk);
            in_valid = 1'b0;
            ct_i     = 64'h0;
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic back_to_back(input logic [63:0] p1, input logic [63:0] p2);
        @(negedge clk);
        ct_i      = encrypt(p1);
        cur_exp   = expect_pt(p1);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        wait_accept();
        @(negedge clk);
        ct_i    = encrypt(p2);
        cur_exp = expect_pt(p2);
        b2b_arm = 1'b1;
        wait_accept();
        @(negedge clk);
        in_valid = 1'b0;
        ct_i     = 64'h0;
        b2b_arm  = 1'b0;
        wait_out_valid();
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic reset_mid_run(input logic [63:0] p);
        int t;
        @(negedge clk);
        ct_i     = encrypt(p);
        cur_exp  = expect_pt(p);
        in_valid = 1'b1;
        wait_accept();
        @(negedge clk);
        in_valid = 1'b0;
        t = 0;
        while (rk_idx_o != 5'd7 && t < LAT + 5) begin
            @(negedge clk);
            t++;
        end
        chk("reached_round7", 64'(rk_idx_o), 64'd7);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (LAT + 3) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        send(64'h0123456789ABCDEF, 0);
        send({$urandom(), $urandom()}, 5);
        for (int i = 0; i < 8; i++) send({$urandom(), $urandom()}, int'($urandom_range(0, 3)));
        back_to_back({$urandom(), $urandom()}, {$urandom(), $urandom()});
        reset_mid_run({$urandom(), $urandom()});
        send({$urandom(), $urandom()}, 1);
        send(64'h0, 0);
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
